// File: rtl/dsm_dac_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dsm_dac_ctrl
// Description : Sample pacing and soft-mute gain ramp in front of a
//               delta-sigma modulator. Soft ramps are built only when
//               DSM_DAC_CTRL_RAMP_EN is defined; otherwise start/stop are hard.
// Revision    : 1.0 - initial release
// ============================================================================
module dsm_dac_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int OSR        = 64,
    parameter int RAMP_SHIFT = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_stop,
    input  logic signed [DATA_WIDTH-1:0] i_s_data,
    input  logic                         i_s_valid,
    output logic                         o_s_ready,
    output logic signed [DATA_WIDTH-1:0] o_dsm_data,
    output logic                         o_dsm_en,
    output logic                         o_busy,
    output logic                         o_underrun
);

    localparam int CW = (OSR > 2) ? $clog2(OSR) : 1;
    localparam int GW = RAMP_SHIFT + 1;
    localparam int PW = DATA_WIDTH + RAMP_SHIFT + 2;

    localparam logic [CW-1:0] c_CNT_MAX   = CW'(OSR - 1);
    localparam logic [GW-1:0] c_GAIN_FULL = GW'(1 << RAMP_SHIFT);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_RUN       = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [CW-1:0]                 r_cnt;
    logic                          r_buf_valid;
    logic signed [DATA_WIDTH-1:0]  r_buf_data;
    logic signed [DATA_WIDTH-1:0]  r_last;

    logic                          w_boundary;
    logic                          w_hs;
    logic                          w_start_req;
    logic                          w_underrun_evt;
    logic signed [DATA_WIDTH-1:0]  w_sample;
    logic signed [DATA_WIDTH-1:0]  w_scaled;
    logic [GW-1:0]                 w_g;

    logic signed [PW-1:0]          w_samp_ext;
    logic signed [PW-1:0]          w_g_ext;
    logic signed [PW-1:0]          w_prod;
    logic signed [PW-1:0]          w_shifted;

`ifdef DSM_DAC_CTRL_RAMP_EN
    logic [GW-1:0]                 r_gain;
    logic [GW-1:0]                 w_gain_nxt;
`endif

    assign o_busy      = (r_state != S_IDLE);
    assign o_dsm_en    = (r_state != S_IDLE);
    assign o_s_ready   = (r_state != S_IDLE) && !r_buf_valid;
    assign w_hs        = i_s_valid && o_s_ready;
    assign w_boundary  = (r_state != S_IDLE) && (r_cnt == c_CNT_MAX);
    // Stop always wins over a coincident start.
    assign w_start_req = i_start && !i_stop;

    // Boundary sample source: buffered entry, then same-cycle bypass, then repeat.
    always_comb begin
        w_sample       = r_last;
        w_underrun_evt = 1'b0;
        if (r_buf_valid) begin
            w_sample = r_buf_data;
        end else if (w_hs) begin
            w_sample = i_s_data;
        end else begin
            w_underrun_evt = w_boundary;
        end
    end

    // Gain is non-negative, so it is zero-extended before the signed multiply.
    assign w_samp_ext = {{(PW-DATA_WIDTH){w_sample[DATA_WIDTH-1]}}, w_sample};
    assign w_g_ext    = {{(PW-GW){1'b0}}, w_g};
    assign w_prod     = w_samp_ext * w_g_ext;
    assign w_shifted  = w_prod >>> RAMP_SHIFT;
    assign w_scaled   = DATA_WIDTH'(w_shifted);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
`ifdef DSM_DAC_CTRL_RAMP_EN
            r_gain  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
`ifdef DSM_DAC_CTRL_RAMP_EN
            r_gain  <= w_gain_nxt;
`endif
        end
    end

`ifdef DSM_DAC_CTRL_RAMP_EN
    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        w_g         = r_gain;
        case (r_state)
            S_IDLE: begin
                w_gain_nxt = '0;
                if (w_start_req) begin
                    w_state_nxt = S_RAMP_UP;
                end
            end
            S_RAMP_UP: begin
                if (w_boundary) begin
                    w_gain_nxt = r_gain + GW'(1);
                    if (w_gain_nxt == c_GAIN_FULL) begin
                        w_state_nxt = S_RUN;
                    end
                end
                if (i_stop) begin
                    w_state_nxt = S_RAMP_DOWN;
                end
            end
            S_RUN: begin
                w_g = c_GAIN_FULL;
                if (i_stop) begin
                    w_state_nxt = S_RAMP_DOWN;
                end
            end
            S_RAMP_DOWN: begin
                // A stop issued before the first ramp-up step leaves gain at 0.
                w_g = (r_gain == '0) ? '0 : (r_gain - GW'(1));
                if (w_boundary) begin
                    w_gain_nxt = w_g;
                    if (w_g == '0) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                if (w_start_req) begin
                    w_state_nxt = S_RAMP_UP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end
`else
    always_comb begin
        w_state_nxt = r_state;
        w_g         = c_GAIN_FULL;
        case (r_state)
            S_IDLE: begin
                if (w_start_req) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RAMP_UP: begin
                w_state_nxt = S_RUN;
                if (i_stop) begin
                    w_state_nxt = S_RAMP_DOWN;
                end
            end
            S_RUN: begin
                if (i_stop) begin
                    w_state_nxt = S_RAMP_DOWN;
                end
            end
            S_RAMP_DOWN: begin
                // Hard mute: one boundary emitting zero, then idle.
                w_g = '0;
                if (w_boundary) begin
                    w_state_nxt = S_IDLE;
                end
                if (w_start_req) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_buf_valid <= 1'b0;
            r_buf_data  <= '0;
            r_last      <= '0;
            o_dsm_data  <= '0;
            o_underrun  <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_cnt       <= '0;
            r_buf_valid <= 1'b0;
            r_last      <= '0;
            o_dsm_data  <= '0;
            if (w_state_nxt != S_IDLE) begin
                o_underrun <= 1'b0;
            end
        end else begin
            r_cnt <= w_boundary ? '0 : (r_cnt + CW'(1));
            if (w_boundary) begin
                r_buf_valid <= 1'b0;
                r_last      <= w_sample;
                o_dsm_data  <= w_scaled;
                if (w_underrun_evt) begin
                    o_underrun <= 1'b1;
                end
            end else if (w_hs) begin
                r_buf_valid <= 1'b1;
                r_buf_data  <= i_s_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dsm_dac_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsm_dac_ctrl
// Description : Self-checking bench for dsm_dac_ctrl (OSR=4, RAMP_SHIFT=2);
//               follows DSM_DAC_CTRL_RAMP_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsm_dac_ctrl;

    localparam int DW   = 16;
    localparam int OSR  = 4;
    localparam int RS   = 2;
    localparam int FULL = 1 << RS;
`ifdef DSM_DAC_CTRL_RAMP_EN
    localparam bit RAMP = 1'b1;
    localparam int UP_POS[5] = '{0, 'h1000, 'h2000, 'h3000, 'h4000};
    localparam int UP_M1[5]  = '{0, -1, -1, -1, -1};
    localparam int UP_M4[5]  = '{0, -'sh1000, -'sh2000, -'sh3000, -'sh4000};
`else
    localparam bit RAMP = 1'b0;
    localparam int UP_POS[5] = '{'h4000, 'h4000, 'h4000, 'h4000, 'h4000};
    localparam int UP_M1[5]  = '{-1, -1, -1, -1, -1};
    localparam int UP_M4[5]  = '{-'sh4000, -'sh4000, -'sh4000, -'sh4000, -'sh4000};
`endif

    logic                 clk = 1'b0;
    logic                 rst, start, stop, s_valid;
    logic signed [DW-1:0] s_data;
    logic                 s_ready, dsm_en, busy, underrun;
    logic signed [DW-1:0] dsm_data;

    int n_cmp = 0;
    int n_bad = 0;

    dsm_dac_ctrl #(.DATA_WIDTH(DW), .OSR(OSR), .RAMP_SHIFT(RS)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_stop     (stop),
        .i_s_data   (s_data),
        .i_s_valid  (s_valid),
        .o_s_ready  (s_ready),
        .o_dsm_data (dsm_data),
        .o_dsm_en   (dsm_en),
        .o_busy     (busy),
        .o_underrun (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int floor_div(input int p, input int d);
        int q;
        q = p / d;
        if ((p % d != 0) && (p < 0)) q = q - 1;
        return q;
    endfunction

    // Reference model: a running/muting flag and an integer gain.
    bit                   m_armed = 1'b0;
    bit                   m_busy, m_down, m_bufv, m_unr;
    int                   m_gain, m_phase, m_g;
    logic signed [DW-1:0] m_bufd, m_last, m_data, m_smp;
    bit                   m_hs, m_bnd;

    always @(posedge clk) begin
        m_g = 0;
        if (rst) begin
            m_armed = 1'b1;
            m_busy = 0; m_down = 0; m_bufv = 0; m_unr = 0;
            m_gain = 0; m_phase = 0; m_bufd = 0; m_last = 0; m_data = 0;
        end else if (!m_busy) begin
            m_data = 0; m_last = 0; m_bufv = 0; m_phase = 0;
            if (start && !stop) begin
                m_busy = 1; m_down = 0; m_unr = 0;
                m_gain = RAMP ? 0 : FULL;
            end
        end else begin
            m_hs  = s_valid && !m_bufv;
            m_bnd = (m_phase == OSR - 1);
            m_phase = m_bnd ? 0 : m_phase + 1;
            if (m_bnd) begin
                if (m_bufv) begin
                    m_smp = m_bufd;
                    m_bufv = 0;
                end else if (m_hs) begin
                    m_smp = s_data;
                end else begin
                    m_smp = m_last;
                    m_unr = 1;
                end
                m_last = m_smp;
                if (!m_down) begin
                    m_g = m_gain;
                    if (m_gain < FULL) m_gain = m_gain + 1;
                end else begin
                    m_g = (RAMP && m_gain > 0) ? m_gain - 1 : 0;
                    m_gain = m_g;
                end
                m_data = DW'(floor_div(int'(m_smp) * m_g, FULL));
            end else if (m_hs) begin
                m_bufv = 1;
                m_bufd = s_data;
            end
            if (start && !stop && m_down) begin
                m_down = 0;
                if (!RAMP) m_gain = FULL;
            end else if (stop && !m_down) begin
                m_down = 1;
            end else if (m_bnd && m_down && m_g == 0) begin
                m_busy = 0; m_bufv = 0; m_gain = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_armed) begin
            chk("m_data", dsm_data, m_data);
            chk("m_en", dsm_en, m_busy);
            chk("m_busy", busy, m_busy);
            chk("m_ready", s_ready, m_busy && !m_bufv);
            chk("m_underrun", underrun, m_unr);
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        wait_n(1);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0;
        wait_n(3);
        chk("rst_data", dsm_data, 0);
        chk("rst_en", dsm_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_underrun", underrun, 0);
        rst = 1'b0;

        // Ramp-up with a positive constant source.
        s_data = 16'sh4000; s_valid = 1'b1;
        start_pulse();
        chk("start_busy", busy, 1);
        chk("start_en", dsm_en, 1);
        chk("start_ready", s_ready, 1);
        for (int k = 0; k < 5; k++) begin
            wait_n(4);
            chk("up_pos", dsm_data, UP_POS[k]);
        end

        // Underrun: source goes quiet for one sample period.
        s_valid = 1'b0;
        wait_n(3);
        chk("unr_pre", underrun, 0);
        wait_n(1);
        chk("unr_set", underrun, 1);
        chk("unr_hold", dsm_data, 'h4000);

        s_valid = 1'b1;
        stop = 1'b1;
        wait_n(1);
        stop = 1'b0;
`ifdef DSM_DAC_CTRL_RAMP_EN
        wait_n(3);  chk("down3", dsm_data, 'h3000);
        wait_n(4);  chk("down2", dsm_data, 'h2000);
        wait_n(4);  chk("down1", dsm_data, 'h1000);
        wait_n(3);  chk("down_last_en", dsm_en, 1);
        wait_n(1);
`else
        wait_n(3);
`endif
        chk("down0", dsm_data, 0);
        chk("down_en", dsm_en, 0);
        chk("down_busy", busy, 0);
        chk("unr_sticky", underrun, 1);

        // Start and stop together from idle.
        start = 1'b1; stop = 1'b1;
        wait_n(1);
        start = 1'b0; stop = 1'b0;
        chk("both_idle", busy, 0);
        chk("both_unr", underrun, 1);

        start_pulse();
        chk("restart_unr", underrun, 0);
        wait_n(20);
        chk("rerun", dsm_data, 'h4000);
        stop = 1'b1;
        wait_n(1);
        stop = 1'b0;
`ifdef DSM_DAC_CTRL_RAMP_EN
        wait_n(3);  chk("rd3", dsm_data, 'h3000);
        wait_n(4);  chk("rd2", dsm_data, 'h2000);
        start_pulse();
        wait_n(3);  chk("ru2", dsm_data, 'h2000);
        wait_n(4);  chk("ru3", dsm_data, 'h3000);
        wait_n(4);  chk("ru4", dsm_data, 'h4000);
        chk("ru_busy", busy, 1);
`else
        wait_n(3);  chk("hard_mute", dsm_data, 0);
        chk("hard_idle", busy, 0);
`endif
        rst = 1'b1;
        wait_n(2);
        rst = 1'b0;

        // Negative rounding with -1, then a mid-run reset.
        s_data = -16'sd1;
        start_pulse();
        for (int k = 0; k < 5; k++) begin
            wait_n(4);
            chk("up_m1", dsm_data, UP_M1[k]);
        end
        rst = 1'b1;
        wait_n(1);
        chk("mrst_data", dsm_data, 0);
        chk("mrst_en", dsm_en, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", s_ready, 0);
        wait_n(1);
        chk("mrst_busy2", busy, 0);
        rst = 1'b0;

        s_data = -16'sh4000;
        start_pulse();
        for (int k = 0; k < 5; k++) begin
            wait_n(4);
            chk("up_m4000", dsm_data, UP_M4[k]);
        end

        // Handshake only in the boundary cycle: bypassed, no underrun.
        s_valid = 1'b0;
        wait_n(3);
        s_valid = 1'b1;
        s_data = 16'sh1234;
        wait_n(1);
        chk("bypass_data", dsm_data, 'h1234);
        chk("bypass_unr", underrun, 0);
        wait_n(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
